// File: rtl/serial_frame_tx.sv
// serial_frame_tx: start/LSB-first data/optional even parity/stop serialiser with registered line output.
// Optional parity bit enabled by defining SERIAL_TX_PARITY_EN.
module serial_frame_tx #(
  parameter int DATA_W     = 8,
  parameter int BIT_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              out_data,
  output logic              out_busy,
  output logic              frame_done
);
  localparam int BW = $clog2(DATA_W) + 1;
  localparam logic [7:0] CYC_LAST = 8'(BIT_CYCLES - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);
  localparam logic LAST_PULSE = (BIT_CYCLES == 1);
`ifdef SERIAL_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  logic par_q;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif
  state_t            state_q;
  logic [7:0]        cyc_q;
  logic [BW-1:0]     bit_q;
  logic [DATA_W-1:0] shreg_q;
  logic              out_data_q;
  logic              frame_done_q;
  assign in_ready   = (state_q == IDLE) && !reset;
  assign out_data   = out_data_q;
  assign out_busy   = state_q != IDLE;
  assign frame_done = frame_done_q;
  // cyc_q counts down to 0; a zero count marks the last cycle of the current bit
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cyc_q        <= '0;
      bit_q        <= '0;
      shreg_q      <= '0;
      out_data_q   <= 1'b1;
      frame_done_q <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      par_q        <= 1'b0;
`endif
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        IDLE: if (in_valid) begin
          state_q    <= START;
          shreg_q    <= in_data;
          cyc_q      <= CYC_LAST;
          out_data_q <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
          par_q      <= ^in_data;
`endif
        end
        START: if (cyc_q == 8'd0) begin
          state_q    <= DATA;
          cyc_q      <= CYC_LAST;
          bit_q      <= '0;
          out_data_q <= shreg_q[0];
        end else cyc_q <= cyc_q - 8'd1;
        DATA: if (cyc_q == 8'd0) begin
          cyc_q   <= CYC_LAST;
          shreg_q <= shreg_q >> 1;
          bit_q   <= bit_q + BW'(1);
          if (bit_q == BIT_LAST) begin
`ifdef SERIAL_TX_PARITY_EN
            state_q    <= PARITY;
            out_data_q <= par_q;
`else
            state_q      <= STOP;
            out_data_q   <= 1'b1;
            frame_done_q <= LAST_PULSE;
`endif
          end else out_data_q <= shreg_q[1];
        end else cyc_q <= cyc_q - 8'd1;
`ifdef SERIAL_TX_PARITY_EN
        PARITY: if (cyc_q == 8'd0) begin
          state_q      <= STOP;
          cyc_q        <= CYC_LAST;
          out_data_q   <= 1'b1;
          frame_done_q <= LAST_PULSE;
        end else cyc_q <= cyc_q - 8'd1;
`endif
        STOP: if (cyc_q == 8'd0) begin
          state_q    <= IDLE;
          out_data_q <= 1'b1;
        end else begin
          cyc_q        <= cyc_q - 8'd1;
          frame_done_q <= cyc_q == 8'd1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_frame_tx.sv
// tb_serial_frame_tx: random and directed frames checked against a per-cycle line model.
module tb_serial_frame_tx;
`ifdef SERIAL_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  logic clk = 1'b0;
  logic reset, v0, v1;
  logic [7:0] in_data;
  logic rdy0, od0, busy0, fd0, rdy1, od1, busy1, fd1;
  int ncmp = 0, nerr = 0;
  always #5 clk = ~clk;
  serial_frame_tx #(.DATA_W(8), .BIT_CYCLES(4)) dut0 (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(v0),
    .in_ready(rdy0), .out_data(od0), .out_busy(busy0), .frame_done(fd0));
  serial_frame_tx #(.DATA_W(8), .BIT_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(v1),
    .in_ready(rdy1), .out_data(od1), .out_busy(busy1), .frame_done(fd1));
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic obs, input logic exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask
  // line model: frame bit j = k/bc is start(0), data LSB first, optional even parity, stop(1)
  task automatic send(input bit sel, input int bc, input logic [7:0] w, input bit keep);
    int len;
    len = (2 + 8 + P) * bc;
    in_data = w;
    if (sel) v1 = 1'b1; else v0 = 1'b1;
    chk("ready_at_accept", sel ? rdy1 : rdy0, 1'b1);
    step();
    if (!keep) begin v0 = 1'b0; v1 = 1'b0; end
    for (int k = 0; k < len; k++) begin
      int j;
      logic e;
      j = k / bc;
      e = (j == 0) ? 1'b0 : (j <= 8) ? w[j-1] : (P == 1 && j == 9) ? ^w : 1'b1;
      chk("out_data", sel ? od1 : od0, e);
      chk("out_busy", sel ? busy1 : busy0, 1'b1);
      chk("frame_done", sel ? fd1 : fd0, k == len - 1);
      chk("ready_mid_frame", sel ? rdy1 : rdy0, 1'b0);
      in_data = 8'($urandom);
      step();
    end
    v0 = 1'b0;
    v1 = 1'b0;
    chk("idle_out_data", sel ? od1 : od0, 1'b1);
    chk("idle_ready", sel ? rdy1 : rdy0, 1'b1);
    chk("idle_busy", sel ? busy1 : busy0, 1'b0);
    chk("idle_done", sel ? fd1 : fd0, 1'b0);
  endtask
  initial begin
    logic [7:0] w;
    reset = 1'b1; v0 = 1'b0; v1 = 1'b0; in_data = 8'h00;
    step();
    chk("rst_ready0", rdy0, 1'b0);
    chk("rst_ready1", rdy1, 1'b0);
    step();
    chk("rst_out0", od0, 1'b1);
    chk("rst_busy0", busy0, 1'b0);
    chk("rst_done0", fd0, 1'b0);
    chk("rst_out1", od1, 1'b1);
    reset = 1'b0;
    #1;
    chk("post_rst_ready0", rdy0, 1'b1);
    chk("post_rst_ready1", rdy1, 1'b1);
    send(1'b0, 4, 8'hA5, 1'b0);
    send(1'b0, 4, 8'h07, 1'b0);
    send(1'b0, 4, 8'h03, 1'b0);
    repeat (3) send(1'b0, 4, 8'($urandom), 1'b1);
    repeat (6) begin
      send(1'b0, 4, 8'($urandom), 1'($urandom));
      repeat ($urandom_range(0, 2)) step();
    end
    w = 8'($urandom);
    in_data = w;
    v0 = 1'b1;
    step();
    v0 = 1'b0;
    repeat (17) step();
    chk("pre_reset_bit3", od0, w[3]);
    reset = 1'b1;
    #1;
    chk("reset_ready_low", rdy0, 1'b0);
    step();
    chk("abort_out", od0, 1'b1);
    chk("abort_busy", busy0, 1'b0);
    chk("abort_done", fd0, 1'b0);
    chk("abort_ready", rdy0, 1'b0);
    step();
    chk("abort2_done", fd0, 1'b0);
    reset = 1'b0;
    #1;
    chk("after_abort_ready", rdy0, 1'b1);
    chk("after_abort_out", od0, 1'b1);
    chk("after_abort_busy", busy0, 1'b0);
    step();
    chk("after_abort_idle_done", fd0, 1'b0);
    send(1'b0, 4, 8'($urandom), 1'b0);
    send(1'b1, 1, 8'hFF, 1'b0);
    repeat (3) send(1'b1, 1, 8'($urandom), 1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
